// File: rtl/tile_renderer_if.sv
// Pixel, sync and memory-port bundle between the timing generator, the tile/bitmap memories and
// tile_renderer; the renderer takes the slave view, the surrounding system the master view.
interface tile_renderer_if #(
  parameter int unsigned Abits = 11,
  parameter int unsigned Dbits = 8,
  parameter int unsigned Sbits = 13,
  parameter int unsigned Cbits = 5
);
  logic [9:0]       x;
  logic [9:0]       y;
  logic             active;
  logic             hsync_in;
  logic             vsync_in;
  logic [Sbits-1:0] screen_addr;
  logic [Cbits-1:0] tile_code;
  logic [Abits-1:0] bitmap_addr;
  logic [Dbits-1:0] bitmap_data;
  logic [Dbits-1:0] rgb;
  logic             hsync;
  logic             vsync;
  logic             active_out;

  modport master (
    output x, y, active, hsync_in, vsync_in, tile_code, bitmap_data,
    input  screen_addr, bitmap_addr, rgb, hsync, vsync, active_out
  );

  modport slave (
    input  x, y, active, hsync_in, vsync_in, tile_code, bitmap_data,
    output screen_addr, bitmap_addr, rgb, hsync, vsync, active_out
  );
endinterface

// File: rtl/tile_renderer.sv
// Three-stage tile renderer: pixel coordinate -> screen memory tile code -> bitmap pixel colour,
// with the sync and active flags delayed to stay aligned with the colour.
module tile_renderer #(
  parameter int unsigned Abits      = 11,
  parameter int unsigned Dbits      = 8,
  parameter int unsigned Sbits      = 13,
  parameter int unsigned Cbits      = 5,
  parameter int unsigned TILE_COUNT = 20
) (
  input logic            clk,
  input logic            reset,
  tile_renderer_if.slave bus
);

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } side_t;

  // Sync lines are active-low, so the idle sideband keeps them high.
  localparam side_t SideIdle = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // Stage 1: screen address and position inside the tile
  logic [Sbits-1:0] tile_row;
  logic [Sbits-1:0] tile_col;
  logic [Sbits-1:0] screen_addr_d;
  logic [Sbits-1:0] screen_addr_q;
  logic [2:0]       fx1_q;
  logic [2:0]       fy1_q;
  side_t            side1_d;
  side_t            side1_q;

  // Stage 2: bitmap address
  logic             code_ok;
  logic [Abits-1:0] bitmap_addr_d;
  logic [Abits-1:0] bitmap_addr_q;
  logic             valid2_q;
  side_t            side2_q;

  // Stage 3: colour and delayed sideband
  logic [Dbits-1:0] rgb_d;
  logic [Dbits-1:0] rgb_q;
  side_t            side3_q;

  // row*80 as row*64 + row*16; wraps silently for off-screen coordinates
  always_comb begin
    tile_row      = Sbits'(bus.y[9:3]);
    tile_col      = Sbits'(bus.x[9:3]);
    screen_addr_d = (tile_row << 6) + (tile_row << 4) + tile_col;
    side1_d       = '{active: bus.active, hsync: bus.hsync_in, vsync: bus.vsync_in};
  end

  always_comb begin
    code_ok       = 32'(bus.tile_code) < TILE_COUNT;
    bitmap_addr_d = '0;
    if (code_ok) begin
      bitmap_addr_d = Abits'({bus.tile_code, fy1_q, fx1_q});
    end
  end

  // Blanking forces black independently of what the bitmap memory returns.
  always_comb begin
    rgb_d = '0;
    if (valid2_q && side2_q.active) begin
      rgb_d = bus.bitmap_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      screen_addr_q <= '0;
      fx1_q         <= '0;
      fy1_q         <= '0;
      side1_q       <= SideIdle;
      bitmap_addr_q <= '0;
      valid2_q      <= 1'b0;
      side2_q       <= SideIdle;
      rgb_q         <= '0;
      side3_q       <= SideIdle;
    end else begin
      screen_addr_q <= screen_addr_d;
      fx1_q         <= bus.x[2:0];
      fy1_q         <= bus.y[2:0];
      side1_q       <= side1_d;
      bitmap_addr_q <= bitmap_addr_d;
      valid2_q      <= code_ok;
      side2_q       <= side1_q;
      rgb_q         <= rgb_d;
      side3_q       <= side2_q;
    end
  end

  assign bus.screen_addr = screen_addr_q;
  assign bus.bitmap_addr = bitmap_addr_q;
  assign bus.rgb         = rgb_q;
  assign bus.active_out  = side3_q.active;
  assign bus.hsync       = side3_q.hsync;
  assign bus.vsync       = side3_q.vsync;

endmodule

// File: tb/tb_tile_renderer.sv
// Self-checking bench for tile_renderer: memories modelled as arrays, expected pixels computed
// from tile arithmetic and queued for the pipeline latency.
module tb_tile_renderer;
  localparam int LAT   = 3;
  localparam int IDLEX = 700;
  localparam int IDLEY = 500;

  typedef struct packed {
    logic [7:0] rgb;
    logic       act;
    logic       hs;
    logic       vs;
  } pix_out_t;

  localparam pix_out_t OutIdle = '{rgb: 8'h00, act: 1'b0, hs: 1'b1, vs: 1'b1};

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [4:0] screen_mem [8192];
  logic [7:0] bitmap_mem [2048];
  pix_out_t   pend [$];

  tile_renderer_if bus ();

  tile_renderer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.tile_code   = screen_mem[bus.screen_addr];
  assign bus.bitmap_data = bitmap_mem[bus.bitmap_addr];

  function automatic pix_out_t model(input int px, input int py, input logic act,
                                     input logic hs, input logic vs);
    int       saddr;
    int       code;
    pix_out_t o;
    saddr = ((py / 8) * 80 + px / 8) % 8192;
    code  = int'(screen_mem[saddr]);
    o.rgb = (act && code < 20) ? bitmap_mem[code * 64 + (py % 8) * 8 + px % 8] : 8'h00;
    o.act = act;
    o.hs  = hs;
    o.vs  = vs;
    return o;
  endfunction

  function automatic pix_out_t observed();
    return {bus.rgb, bus.active_out, bus.hsync, bus.vsync};
  endfunction

  task automatic fill_random();
    for (int a = 0; a < 8192; a++) screen_mem[a] = 5'($urandom_range(0, 31));
    for (int a = 0; a < 2048; a++) bitmap_mem[a] = (a < 1280) ? 8'($urandom) : 8'hFF;
  endtask

  task automatic restart_pipe();
    pend.delete();
    repeat (LAT - 1) pend.push_back(OutIdle);
  endtask

  // Apply one pixel, clock it, and return the expectation now due at the outputs.
  task automatic cycle(input int px, input int py, input logic act, input logic hs,
                       input logic vs, output pix_out_t e);
    bus.x        = 10'(px);
    bus.y        = 10'(py);
    bus.active   = act;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    pend.push_back(model(px, py, act, hs, vs));
    @(posedge clk);
    #1;
    e = pend.pop_front();
  endtask

  task automatic test_reset();
    checks++;
    if (bus.rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb got %h want 00", bus.rgb); end
    checks++;
    if (bus.active_out !== 1'b0) begin
      errors++; $display("FAIL reset_active got %b want 0", bus.active_out);
    end
    checks++;
    if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin
      errors++; $display("FAIL reset_sync got %b%b want 11", bus.hsync, bus.vsync);
    end
    checks++;
    if (bus.screen_addr !== 13'd0 || bus.bitmap_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset_addr got %0d/%0d want 0/0", bus.screen_addr, bus.bitmap_addr);
    end
    reset = 1'b0;
    restart_pipe();
  endtask

  task automatic test_address();
    pix_out_t e;
    screen_mem[161] = 5'd3;
    bitmap_mem[237] = 8'hE3;
    cycle(13, 21, 1'b1, 1'b1, 1'b1, e);
    checks++;
    if (bus.screen_addr !== 13'd161) begin
      errors++; $display("FAIL addr_screen got %0d want 161", bus.screen_addr);
    end
    checks++;
    if (observed() !== e) begin errors++; $display("FAIL addr_out1 got %h want %h", observed(), e); end
    cycle(IDLEX, IDLEY, 1'b0, 1'b1, 1'b1, e);
    checks++;
    if (bus.bitmap_addr !== 11'd237) begin
      errors++; $display("FAIL addr_bitmap got %0d want 237", bus.bitmap_addr);
    end
    cycle(IDLEX, IDLEY, 1'b0, 1'b1, 1'b1, e);
    checks++;
    if (bus.rgb !== 8'hE3) begin errors++; $display("FAIL addr_rgb got %h want e3", bus.rgb); end
    checks++;
    if (observed() !== e) begin errors++; $display("FAIL addr_out3 got %h want %h", observed(), e); end
  endtask

  task automatic test_corners();
    pix_out_t e;
    screen_mem[0]    = 5'd0;
    screen_mem[4799] = 5'd19;
    screen_mem[5047] = 5'd7;
    bitmap_mem[0]    = 8'h11;
    bitmap_mem[1279] = 8'h22;
    cycle(0, 0, 1'b1, 1'b1, 1'b1, e);
    checks++;
    if (bus.screen_addr !== 13'd0) begin
      errors++; $display("FAIL corner_screen0 got %0d want 0", bus.screen_addr);
    end
    cycle(639, 479, 1'b1, 1'b1, 1'b1, e);
    checks++;
    if (bus.screen_addr !== 13'd4799 || bus.bitmap_addr !== 11'd0) begin
      errors++;
      $display("FAIL corner_mid got %0d/%0d want 4799/0", bus.screen_addr, bus.bitmap_addr);
    end
    cycle(IDLEX, IDLEY, 1'b0, 1'b1, 1'b1, e);
    checks++;
    if (bus.bitmap_addr !== 11'd1279 || bus.rgb !== 8'h11) begin
      errors++;
      $display("FAIL corner_top got %0d/%h want 1279/11", bus.bitmap_addr, bus.rgb);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(IDLEX, IDLEY, 1'b0, 1'b1, 1'b1, e);
      checks++;
      if (observed() !== e) begin
        errors++; $display("FAIL corner_out got %h want %h", observed(), e);
      end
    end
  endtask

  task automatic test_invalid();
    pix_out_t e;
    screen_mem[163] = 5'd25;
    screen_mem[164] = 5'd4;
    bitmap_mem[0]   = 8'hFF;
    bitmap_mem[256] = 8'h5A;
    cycle(24, 16, 1'b1, 1'b1, 1'b1, e);
    cycle(32, 16, 1'b1, 1'b1, 1'b1, e);
    checks++;
    if (bus.bitmap_addr !== 11'd0) begin
      errors++; $display("FAIL invalid_addr got %0d want 0", bus.bitmap_addr);
    end
    cycle(IDLEX, IDLEY, 1'b0, 1'b1, 1'b1, e);
    checks++;
    if (bus.rgb !== 8'h00 || bus.bitmap_addr !== 11'd256) begin
      errors++; $display("FAIL invalid_rgb got %h/%0d want 00/256", bus.rgb, bus.bitmap_addr);
    end
    cycle(IDLEX, IDLEY, 1'b0, 1'b1, 1'b1, e);
    checks++;
    if (bus.rgb !== 8'h5A) begin errors++; $display("FAIL invalid_next got %h want 5a", bus.rgb); end
    checks++;
    if (observed() !== e) begin errors++; $display("FAIL invalid_out got %h want %h", observed(), e); end
    cycle(IDLEX, IDLEY, 1'b0, 1'b1, 1'b1, e);
  endtask

  task automatic test_blanking();
    pix_out_t e;
    bit seen_active = 1'b0;
    int blank_at = -1;
    int hs_at = -1;
    int hs_len = 0;
    fill_random();
    for (int i = 0; i < 800 + LAT; i++) begin
      if (i < 800) cycle(i, 100, i < 640, !(i >= 656 && i < 752), 1'b1, e);
      else cycle(IDLEX, IDLEY, 1'b0, 1'b1, 1'b1, e);
      checks++;
      if (observed() !== e) begin
        errors++; $display("FAIL blank_line[%0d] got %h want %h", i, observed(), e);
      end
      if (bus.active_out === 1'b1) seen_active = 1'b1;
      if (seen_active && bus.active_out === 1'b0 && blank_at < 0) blank_at = i;
      if (bus.active_out === 1'b0) begin
        checks++;
        if (bus.rgb !== 8'h00) begin
          errors++; $display("FAIL blank_rgb[%0d] got %h want 00", i, bus.rgb);
        end
      end
      if (bus.hsync === 1'b0) begin
        if (hs_at < 0) hs_at = i;
        hs_len++;
      end
    end
    checks++;
    if (blank_at != 640 + LAT - 1) begin
      errors++; $display("FAIL blank_start got %0d want %0d", blank_at, 640 + LAT - 1);
    end
    checks++;
    if (hs_at != 656 + LAT - 1 || hs_len != 96) begin
      errors++;
      $display("FAIL hsync_pulse got %0d/%0d want %0d/96", hs_at, hs_len, 656 + LAT - 1);
    end
  endtask

  task automatic test_back_to_back();
    pix_out_t   e;
    logic [7:0] want;
    screen_mem[80] = 5'd1;
    screen_mem[81] = 5'd2;
    for (int a = 0; a < 1280; a++) bitmap_mem[a] = 8'(a);
    for (int i = 0; i < 16 + LAT; i++) begin
      if (i < 16) cycle(i, 8, 1'b1, 1'b1, 1'b1, e);
      else cycle(IDLEX, IDLEY, 1'b0, 1'b1, 1'b1, e);
      if (i >= LAT - 1 && i - (LAT - 1) < 16) begin
        want = 8'(((i - 2) < 8 ? 1 : 2) * 64 + (i - 2) % 8);
        checks++;
        if (bus.rgb !== want || bus.active_out !== 1'b1) begin
          errors++; $display("FAIL b2b_px%0d got %h want %h", i - 2, bus.rgb, want);
        end
      end
      checks++;
      if (observed() !== e) begin errors++; $display("FAIL b2b_out got %h want %h", observed(), e); end
    end
  endtask

  task automatic test_random();
    pix_out_t e;
    logic     act;
    fill_random();
    for (int i = 0; i < 1500 + LAT; i++) begin
      act = ($urandom_range(0, 3) != 0) && (i < 1500);
      if (act) cycle($urandom_range(0, 639), $urandom_range(0, 479), 1'b1,
                     1'($urandom), 1'($urandom), e);
      else if (i < 1500) cycle($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0,
                               1'($urandom), 1'($urandom), e);
      else cycle(IDLEX, IDLEY, 1'b0, 1'b1, 1'b1, e);
      checks++;
      if (observed() !== e) begin errors++; $display("FAIL random[%0d] got %h want %h", i, observed(), e); end
    end
  endtask

  task automatic test_reset_midframe();
    pix_out_t e;
    fill_random();
    screen_mem[81]  = 5'd5;
    bitmap_mem[320] = 8'hC3;
    for (int i = 0; i < 6; i++) begin
      cycle($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b0, 1'b0, e);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (observed() !== OutIdle) begin
      errors++; $display("FAIL midreset_out got %h want %h", observed(), OutIdle);
    end
    checks++;
    if (bus.screen_addr !== 13'd0 || bus.bitmap_addr !== 11'd0) begin
      errors++;
      $display("FAIL midreset_addr got %0d/%0d want 0/0", bus.screen_addr, bus.bitmap_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    restart_pipe();
    for (int i = 0; i < LAT + 1; i++) begin
      if (i == 0) cycle(8, 8, 1'b1, 1'b1, 1'b1, e);
      else cycle(IDLEX, IDLEY, 1'b0, 1'b1, 1'b1, e);
      checks++;
      if (i == LAT - 1) begin
        if (bus.rgb !== 8'hC3 || bus.active_out !== 1'b1) begin
          errors++; $display("FAIL midreset_first got %h/%b want c3/1", bus.rgb, bus.active_out);
        end
      end else if (bus.rgb !== 8'h00 || bus.active_out !== 1'b0) begin
        errors++; $display("FAIL midreset_edge%0d got %h/%b want 00/0", i + 1, bus.rgb, bus.active_out);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.x        = 10'(IDLEX);
    bus.y        = 10'(IDLEY);
    bus.active   = 1'b0;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    fill_random();
    screen_mem[5047] = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_address();
    test_corners();
    test_invalid();
    test_blanking();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
